// File: rtl/tick_event_timer_if.sv
// Control and event bundle of the tick event timer.
// slave side is the timer, master side is its user.
interface tick_event_timer_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] period;
  logic             auto_reload;
  logic             expire_ack;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             expire_valid;
  logic             overrun;

  modport slave (
    input  start, stop, period, auto_reload, expire_ack,
    output tick, count, busy, expire_valid, overrun
  );

  modport master (
    output start, stop, period, auto_reload, expire_ack,
    input  tick, count, busy, expire_valid, overrun
  );
endinterface

// File: rtl/tick_event_timer.sv
// Counts rising edges of a divided clock sampled as data and raises
// an expire event with valid/ack, auto-reload and sticky overrun.
module tick_event_timer #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_clk_in,
  tick_event_timer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic             div_prev;
  logic             rise;
  logic             start_ok;
  logic             accept;
  logic             exp_evt;
  logic             ack_ok;
  logic             busy_w;
  logic             tick_q;
  logic             valid_q;
  logic             ovr_q;
  logic             reload_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] count_q;

  assign rise     = div_clk_in & ~div_prev;
  assign start_ok = bus.start & (bus.period != '0);
  // A start is taken in IDLE/RUN only, and never against a stop.
  assign accept   = start_ok & ~bus.stop & (state_q != DONE);
  assign ack_ok   = valid_q & bus.expire_ack;
  // Expiry needs an edge that was not dropped by stop or restart.
  assign exp_evt  = (state_q == RUN) & rise & ~bus.stop
                  & ~start_ok & (count_q == ONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, priority stop > start > edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (bus.stop)                   state_d = IDLE;
        else if (exp_evt & ~reload_reg) state_d = DONE;
      end
      DONE: if (bus.stop | ack_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_w = (state_q == RUN) | (state_q == DONE);
  end

  // Edge sampling and the registered tick pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_prev <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_prev <= div_clk_in;
      tick_q   <= rise;
    end
  end

  // Period capture and the remaining-tick counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_reg <= '0;
      reload_reg <= 1'b0;
      count_q    <= '0;
    end else if (bus.stop) begin
      count_q <= '0;
    end else if (accept) begin
      period_reg <= bus.period;
      reload_reg <= bus.auto_reload;
      count_q    <= bus.period;
    end else if (state_q == RUN && rise) begin
      if (count_q != ONE)  count_q <= count_q - ONE;
      else if (reload_reg) count_q <= period_reg;
      else                 count_q <= '0;
    end
  end

  // Expire handshake and the sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (exp_evt)     valid_q <= 1'b1;
      else if (ack_ok) valid_q <= 1'b0;
      if (accept)                  ovr_q <= 1'b0;
      else if (exp_evt & valid_q & ~bus.expire_ack) ovr_q <= 1'b1;
    end
  end

  assign bus.tick         = tick_q;
  assign bus.count        = count_q;
  assign bus.busy         = busy_w;
  assign bus.expire_valid = valid_q;
  assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_tick_event_timer.sv
// Randomised and directed bench for tick_event_timer against a
// cycle-level behavioural model of the timer rules.
module tb_tick_event_timer;
  logic clk = 1'b0;
  logic rst;
  logic div;
  int   tests = 0;
  int   fails = 0;
  int   div_mode = 0;
  int   div_cnt = 0;
  int   tick_seen;

  tick_event_timer_if #(.CNT_W(8)) bus ();

  tick_event_timer #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_clk_in (div),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit running;
    bit holding;
    bit prev;
    bit tick;
    bit ev;
    bit ovr;
    bit rl;
    int cnt;
    int per;
  } model_t;

  model_t m;

  function automatic model_t next_model(
    model_t c, bit d, bit st, bit sp, int p, bit ar, bit ack
  );
    model_t n = c;
    bit e    = d && !c.prev;
    bit go   = st && p != 0;
    bit acc  = c.ev && ack;
    bit fire = 0;
    n.prev = d;
    n.tick = e;
    if (sp) begin
      n.running = 0;
      n.holding = 0;
      n.cnt = 0;
    end else if (go && !c.holding) begin
      n.running = 1;
      n.per = p;
      n.rl = ar;
      n.cnt = p;
      n.ovr = 0;
    end else if (c.running && e) begin
      if (c.cnt > 1) n.cnt = c.cnt - 1;
      else begin
        fire = 1;
        if (c.rl) n.cnt = c.per;
        else begin
          n.cnt = 0;
          n.running = 0;
          n.holding = 1;
        end
      end
    end else if (c.holding && acc) begin
      n.holding = 0;
    end
    if (fire) begin
      if (c.ev && !ack) n.ovr = 1;
      n.ev = 1;
    end else if (acc) begin
      n.ev = 0;
    end
    return n;
  endfunction

  // Reference model advanced on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{default: 0};
    else m <= next_model(m, div, bus.start, bus.stop,
                         int'(bus.period), bus.auto_reload,
                         bus.expire_ack);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_tick", 32'(bus.tick), 32'(m.tick));
    chk("m_count", 32'(bus.count), 32'(m.cnt));
    chk("m_busy", 32'(bus.busy), 32'(m.running | m.holding));
    chk("m_valid", 32'(bus.expire_valid), 32'(m.ev));
    chk("m_overrun", 32'(bus.overrun), 32'(m.ovr));
  end

  task automatic step();
    @(negedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.expire_ack = 1'b0;
    if (div_mode == 1) begin
      div_cnt++;
      if (div_cnt >= 5) begin
        div = ~div;
        div_cnt = 0;
      end
    end else if (div_mode == 2) begin
      if ($urandom_range(0, 2) == 0) div = ~div;
    end
  endtask

  task automatic wait_tick(string nm);
    bit got = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (m.tick) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s: got no tick expected tick", nm);
    end
  endtask

  task automatic go(int p, bit ar);
    bus.start = 1'b1;
    bus.period = 8'(p);
    bus.auto_reload = ar;
  endtask

  initial begin
    rst = 1'b1;
    div = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.period = '0;
    bus.auto_reload = 1'b0;
    bus.expire_ack = 1'b0;
    step();
    step();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.expire_valid), 0);
    rst = 1'b0;
    step();

    // One-shot period 3.
    go(3, 0);
    step();
    chk("os_load", 32'(bus.count), 3);
    div_mode = 1;
    div_cnt = 0;
    wait_tick("os_t1");
    chk("os_c2", 32'(bus.count), 2);
    wait_tick("os_t2");
    chk("os_c1", 32'(bus.count), 1);
    wait_tick("os_t3");
    chk("os_c0", 32'(bus.count), 0);
    chk("os_valid", 32'(bus.expire_valid), 1);
    chk("os_busy", 32'(bus.busy), 1);
    step();
    chk("os_hold", 32'(bus.busy), 1);
    bus.expire_ack = 1'b1;
    step();
    chk("os_ackv", 32'(bus.expire_valid), 0);
    chk("os_idle", 32'(bus.busy), 0);

    // Auto-reload period 2, never acknowledged.
    div_mode = 0;
    div = 1'b0;
    step();
    go(2, 1);
    step();
    div_mode = 1;
    div_cnt = 0;
    wait_tick("ar_t1");
    chk("ar_c1", 32'(bus.count), 1);
    wait_tick("ar_t2");
    chk("ar_v2", 32'(bus.expire_valid), 1);
    chk("ar_o2", 32'(bus.overrun), 0);
    chk("ar_c2", 32'(bus.count), 2);
    wait_tick("ar_t3");
    wait_tick("ar_t4");
    chk("ar_o4", 32'(bus.overrun), 1);
    chk("ar_c4", 32'(bus.count), 2);
    go(5, 1);
    step();
    chk("ar_rst_o", 32'(bus.overrun), 0);
    chk("ar_rst_c", 32'(bus.count), 5);
    chk("ar_rst_v", 32'(bus.expire_valid), 1);
    bus.stop = 1'b1;
    step();
    chk("ar_stop_b", 32'(bus.busy), 0);
    chk("ar_stop_v", 32'(bus.expire_valid), 1);
    bus.expire_ack = 1'b1;
    step();
    div_mode = 0;
    div = 1'b0;
    step();

    // Period 1 with ack landing on the next expire.
    go(1, 1);
    step();
    div = 1'b1;
    step();
    chk("p1_v", 32'(bus.expire_valid), 1);
    chk("p1_c", 32'(bus.count), 1);
    div = 1'b0;
    step();
    div = 1'b1;
    bus.expire_ack = 1'b1;
    step();
    chk("p1_ack_v", 32'(bus.expire_valid), 1);
    chk("p1_ack_o", 32'(bus.overrun), 0);
    div = 1'b0;
    step();
    div = 1'b1;
    step();
    chk("p1_ovr", 32'(bus.overrun), 1);
    bus.stop = 1'b1;
    step();
    bus.expire_ack = 1'b1;
    div = 1'b0;
    step();

    // Zero period and start+stop collisions in IDLE.
    go(0, 0);
    step();
    chk("z_busy", 32'(bus.busy), 0);
    chk("z_count", 32'(bus.count), 0);
    go(4, 0);
    bus.stop = 1'b1;
    step();
    chk("ss_busy", 32'(bus.busy), 0);
    chk("ss_count", 32'(bus.count), 0);

    // Restart coinciding with an edge drops the edge.
    go(2, 0);
    step();
    chk("rs_c2", 32'(bus.count), 2);
    go(7, 0);
    div = 1'b1;
    step();
    chk("rs_c7", 32'(bus.count), 7);
    chk("rs_tick", 32'(bus.tick), 1);
    bus.stop = 1'b1;
    div = 1'b0;
    step();

    // Asynchronous reset mid-run.
    go(1, 0);
    step();
    div = 1'b1;
    step();
    chk("ar0_v", 32'(bus.expire_valid), 1);
    bus.stop = 1'b1;
    step();
    go(5, 0);
    step();
    chk("ar0_c5", 32'(bus.count), 5);
    chk("ar0_v1", 32'(bus.expire_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar0_zc", 32'(bus.count), 0);
    chk("ar0_zb", 32'(bus.busy), 0);
    chk("ar0_zv", 32'(bus.expire_valid), 0);
    chk("ar0_zt", 32'(bus.tick), 0);
    step();
    rst = 1'b0;
    tick_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      tick_seen += int'(bus.tick);
    end
    chk("ar0_one_tick", 32'(tick_seen), 1);
    chk("ar0_no_exp", 32'(bus.expire_valid), 0);

    // Random traffic against the model.
    div_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 19) == 0) begin
        bus.start = 1'b1;
        bus.period = ($urandom_range(0, 15) == 0) ? 8'd255 :
                     8'($urandom_range(0, 4));
        bus.auto_reload = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 59) == 0) bus.stop = 1'b1;
      if ($urandom_range(0, 3) == 0) bus.expire_ack = 1'b1;
    end
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
